ps2_mouse_packet_rx: RTL and testbench

Deserializes the raw PS/2 mouse bit stream into 11-bit frames, assembles standard 3-byte mouse packets, and integrates the movement deltas into a clamped absolute cursor position. It sits directly upstream of the mouse controller stage, which consumes its button and position outputs. All logic is clocked by the mouse-driven PS2_CLK. Host-to-device transmission is out of scope: the block is receive-only.

---
 rtl/ps2_mouse_packet_rx_if.sv | 39 +++
 rtl/ps2_mouse_packet_rx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_mouse_packet_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_packet_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_mouse_packet_rx_if
//   Output bundle of the PS/2 mouse packet receiver, consumed by the
//   downstream mouse controller stage.
//
//   button_left/right/middle : latched button state of the last good packet
//   dx, dy                   : signed 9-bit deltas of the last good packet
//   x, y                     : clamped absolute cursor position
//   pkt_valid                : one-cycle pulse when a packet is accepted
//   frame_err                : one-cycle pulse on a parity or stop-bit error
//   sync_err                 : one-cycle pulse when a header byte is rejected
//
//   master : the receiver (drives everything)
//   slave  : the consumer (reads everything)
// ---------------------------------------------------------------------------
interface ps2_mouse_packet_rx_if;
    logic              button_left;
    logic              button_right;
    logic              button_middle;
    logic signed [8:0] dx;
    logic signed [8:0] dy;
    logic [10:0]       x;
    logic [10:0]       y;
    logic              pkt_valid;
    logic              frame_err;
    logic              sync_err;

    modport master (
        output button_left, button_right, button_middle,
        output dx, dy, x, y,
        output pkt_valid, frame_err, sync_err
    );

    modport slave (
        input button_left, button_right, button_middle,
        input dx, dy, x, y,
        input pkt_valid, frame_err, sync_err
    );
endinterface

// File: rtl/ps2_mouse_packet_rx.sv
// ---------------------------------------------------------------------------
// ps2_mouse_packet_rx
//   Receive-only PS/2 mouse front end. Deserializes 11-bit frames (start,
//   8 data LSB first, odd parity, stop) sampled on the rising edge of the
//   device clock, assembles 3-byte mouse packets and integrates the deltas
//   into a clamped absolute cursor position.
//
//   PS2_CLK : device-driven clock, all state updates on its rising edge
//   reset   : synchronous, active-high
//   PS2_DAT : serial data from the mouse
//   mouse   : output bundle (buttons, dx/dy, x/y, status pulses)
// ---------------------------------------------------------------------------
module ps2_mouse_packet_rx #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                  PS2_CLK,
    input  logic                  reset,
    input  logic                  PS2_DAT,
    ps2_mouse_packet_rx_if.master mouse
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic signed [12:0] X_MAX = 13'(WIDTH - 1);
    localparam logic signed [12:0] Y_MAX = 13'(HEIGHT - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [1:0]        idx_q, idx_d;
    // Header byte without its always-one sync bit:
    // [6]=Y ovf [5]=X ovf [4]=Y sign [3]=X sign [2]=M [1]=R [0]=L
    logic [6:0]        hdr_q, hdr_d;
    logic [7:0]        xmag_q, xmag_d;
    logic              btn_l_q, btn_l_d;
    logic              btn_r_q, btn_r_d;
    logic              btn_m_q, btn_m_d;
    logic signed [8:0] dx_q, dx_d;
    logic signed [8:0] dy_q, dy_d;
    logic [10:0]       x_q, x_d;
    logic [10:0]       y_q, y_d;
    logic              pkt_q, pkt_d;
    logic              ferr_q, ferr_d;
    logic              serr_q, serr_d;

    // Byte-2 candidate values; only committed when byte 2's stop bit is good.
    logic signed [8:0]  dx_new, dy_new;
    logic signed [12:0] x_sum, y_sum;
    logic [10:0]        x_clamped, y_clamped;
    logic               byte_ok;

    // Odd parity over data+parity, and the stop bit is the bit being sampled now.
    assign byte_ok = (^{shift_q, par_q}) & PS2_DAT;

    assign dx_new = hdr_q[5] ? 9'sd0 : $signed({hdr_q[3], xmag_q});
    assign dy_new = hdr_q[6] ? 9'sd0 : $signed({hdr_q[4], shift_q});

    // +Y from the mouse is up, screen y grows downward.
    assign x_sum = $signed({2'b00, x_q}) + $signed({{4{dx_new[8]}}, dx_new});
    assign y_sum = $signed({2'b00, y_q}) - $signed({{4{dy_new[8]}}, dy_new});

    always_comb begin
        x_clamped = x_sum[10:0];
        if (x_sum < 13'sd0) begin
            x_clamped = 11'd0;
        end else if (x_sum > X_MAX) begin
            x_clamped = X_MAX[10:0];
        end
        y_clamped = y_sum[10:0];
        if (y_sum < 13'sd0) begin
            y_clamped = 11'd0;
        end else if (y_sum > Y_MAX) begin
            y_clamped = Y_MAX[10:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        hdr_d   = hdr_q;
        xmag_d  = xmag_q;
        btn_l_d = btn_l_q;
        btn_r_d = btn_r_q;
        btn_m_d = btn_m_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        x_d     = x_q;
        y_d     = y_q;
        pkt_d   = 1'b0;
        ferr_d  = 1'b0;
        serr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!PS2_DAT) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                end
            end
            ST_DATA: begin
                shift_d[cnt_q] = PS2_DAT;
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                par_d   = PS2_DAT;
                state_d = ST_STOP;
            end
            default: begin
                state_d = ST_IDLE;
                if (!byte_ok) begin
                    // A corrupted byte breaks packet alignment: restart at the header.
                    ferr_d = 1'b1;
                    idx_d  = 2'd0;
                end else begin
                    case (idx_q)
                        2'd0: begin
                            if (!shift_q[3]) begin
                                serr_d = 1'b1;
                            end else begin
                                hdr_d = {shift_q[7:4], shift_q[2:0]};
                                idx_d = 2'd1;
                            end
                        end
                        2'd1: begin
                            xmag_d = shift_q;
                            idx_d  = 2'd2;
                        end
                        2'd2: begin
                            btn_l_d = hdr_q[0];
                            btn_r_d = hdr_q[1];
                            btn_m_d = hdr_q[2];
                            dx_d    = dx_new;
                            dy_d    = dy_new;
                            x_d     = x_clamped;
                            y_d     = y_clamped;
                            pkt_d   = 1'b1;
                            idx_d   = 2'd0;
                        end
                        default: idx_d = 2'd0;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge PS2_CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            idx_q   <= 2'd0;
            hdr_q   <= 7'd0;
            xmag_q  <= 8'd0;
            btn_l_q <= 1'b0;
            btn_r_q <= 1'b0;
            btn_m_q <= 1'b0;
            dx_q    <= 9'sd0;
            dy_q    <= 9'sd0;
            x_q     <= 11'(WIDTH / 2);
            y_q     <= 11'(HEIGHT / 2);
            pkt_q   <= 1'b0;
            ferr_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            xmag_q  <= xmag_d;
            btn_l_q <= btn_l_d;
            btn_r_q <= btn_r_d;
            btn_m_q <= btn_m_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pkt_q   <= pkt_d;
            ferr_q  <= ferr_d;
            serr_q  <= serr_d;
        end
    end

    assign mouse.button_left   = btn_l_q;
    assign mouse.button_right  = btn_r_q;
    assign mouse.button_middle = btn_m_q;
    assign mouse.dx            = dx_q;
    assign mouse.dy            = dy_q;
    assign mouse.x             = x_q;
    assign mouse.y             = y_q;
    assign mouse.pkt_valid     = pkt_q;
    assign mouse.frame_err     = ferr_q;
    assign mouse.sync_err      = serr_q;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_packet_rx
//   Directed bench for ps2_mouse_packet_rx. Each byte sent updates a small
//   behavioural model; every expected status pulse is queued with the edge
//   number on which it must appear and popped by a monitor when the DUT
//   pulses. One line is printed per popped event.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_packet_rx;

    localparam int WIDTH  = 640;
    localparam int HEIGHT = 480;

    logic PS2_CLK = 1'b0;
    logic reset   = 1'b1;
    logic PS2_DAT = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    ps2_mouse_packet_rx_if mouse_if ();

    ps2_mouse_packet_rx #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .PS2_CLK (PS2_CLK),
        .reset   (reset),
        .PS2_DAT (PS2_DAT),
        .mouse   (mouse_if)
    );

    always #5 PS2_CLK = ~PS2_CLK;

    always @(posedge PS2_CLK) edge_cnt <= edge_cnt + 1;

    // kind = {pkt_valid, frame_err, sync_err}
    typedef struct {
        int                edge_no;
        logic [2:0]        kind;
        logic              bl, br, bm;
        logic signed [8:0] dx, dy;
        logic [10:0]       x, y;
    } exp_t;

    exp_t sb[$];

    // Model state
    int                m_x, m_y, m_idx;
    logic              m_bl, m_br, m_bm;
    logic signed [8:0] m_dx, m_dy;
    logic [7:0]        m_b0, m_b1;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_x = WIDTH / 2; m_y = HEIGHT / 2; m_idx = 0;
        m_bl = 0; m_br = 0; m_bm = 0; m_dx = 0; m_dy = 0;
        m_b0 = 0; m_b1 = 0;
    endtask

    task automatic push(input logic [2:0] kind, input int edge_no);
        exp_t e;
        e.edge_no = edge_no; e.kind = kind;
        e.bl = m_bl; e.br = m_br; e.bm = m_bm;
        e.dx = m_dx; e.dy = m_dy;
        e.x = 11'(m_x); e.y = 11'(m_y);
        sb.push_back(e);
    endtask

    // Byte-level model: decides what the stop edge of this byte must produce.
    task automatic model_byte(input logic [7:0] b, input bit bad, input int edge_no);
        int ddx, ddy;
        if (bad) begin
            m_idx = 0;
            push(3'b010, edge_no);
        end else if (m_idx == 0) begin
            if (!b[3]) push(3'b001, edge_no);
            else begin m_b0 = b; m_idx = 1; end
        end else if (m_idx == 1) begin
            m_b1 = b; m_idx = 2;
        end else begin
            ddx = m_b0[6] ? 0 : (m_b0[4] ? int'(m_b1) - 256 : int'(m_b1));
            ddy = m_b0[7] ? 0 : (m_b0[5] ? int'(b) - 256 : int'(b));
            m_x  = clamp(m_x + ddx, WIDTH - 1);
            m_y  = clamp(m_y - ddy, HEIGHT - 1);
            m_bl = m_b0[0]; m_br = m_b0[1]; m_bm = m_b0[2];
            m_dx = 9'(ddx); m_dy = 9'(ddy);
            m_idx = 0;
            push(3'b100, edge_no);
        end
    endtask

    task automatic send_bit(input logic v);
        @(negedge PS2_CLK);
        PS2_DAT = v;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        logic p;
        p = ~^b;
        if (bad) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        @(negedge PS2_CLK);
        PS2_DAT = 1'b1;
        model_byte(b, bad, edge_cnt + 1);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 0);
        send_byte(b1, 0);
        send_byte(b2, 0);
    endtask

    // Wait for the stop edge of the last byte to register.
    task automatic settle();
        @(negedge PS2_CLK);
    endtask

    task automatic do_reset();
        @(negedge PS2_CLK);
        reset   = 1'b1;
        PS2_DAT = 1'b1;
        @(negedge PS2_CLK);
        check("rst_x", mouse_if.x, 320);
        check("rst_y", mouse_if.y, 240);
        check("rst_btn", {mouse_if.button_left, mouse_if.button_right, mouse_if.button_middle}, 0);
        check("rst_dx", mouse_if.dx, 0);
        check("rst_dy", mouse_if.dy, 0);
        check("rst_pulses", {mouse_if.pkt_valid, mouse_if.frame_err, mouse_if.sync_err}, 0);
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: pop one expectation per status pulse; flag late/missing ones.
    always @(negedge PS2_CLK) begin
        exp_t e;
        if (sb.size() > 0 && edge_cnt > sb[0].edge_no) begin
            check("missing_event_edge", edge_cnt, sb[0].edge_no);
            void'(sb.pop_front());
        end
        if (mouse_if.pkt_valid === 1'b1 || mouse_if.frame_err === 1'b1 ||
            mouse_if.sync_err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_event",
                      {mouse_if.pkt_valid, mouse_if.frame_err, mouse_if.sync_err}, 0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {mouse_if.pkt_valid, mouse_if.frame_err, mouse_if.sync_err}, e.kind);
                check("event_edge", edge_cnt, e.edge_no);
                check("btn_l", mouse_if.button_left, e.bl);
                check("btn_r", mouse_if.button_right, e.br);
                check("btn_m", mouse_if.button_middle, e.bm);
                check("dx", mouse_if.dx, e.dx);
                check("dy", mouse_if.dy, e.dy);
                check("x", mouse_if.x, e.x);
                check("y", mouse_if.y, e.y);
                $display("event kind=%b edge=%0d btn=%b%b%b dx=%0d dy=%0d x=%0d y=%0d",
                         e.kind, edge_cnt, mouse_if.button_left, mouse_if.button_right,
                         mouse_if.button_middle, mouse_if.dx, mouse_if.dy,
                         mouse_if.x, mouse_if.y);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge PS2_CLK);

        // Basic packet: left button, +5/+3
        do_reset();
        send_pkt(8'h09, 8'h05, 8'h03);
        settle();
        check("p1_x", mouse_if.x, 325);
        check("p1_y", mouse_if.y, 237);

        // Negative X delta
        do_reset();
        send_pkt(8'h18, 8'hF6, 8'h00);
        settle();
        check("p2_dx", mouse_if.dx, -10);
        check("p2_x", mouse_if.x, 310);

        // Right-edge clamp
        do_reset();
        send_pkt(8'h08, 8'hFF, 8'h00);
        settle();
        check("p3_x1", mouse_if.x, 575);
        send_pkt(8'h08, 8'hFF, 8'h00);
        settle();
        check("p3_x2", mouse_if.x, 639);

        // 0x38,0x00,0xFF: dx=-256, dy=-1 (y grows): drives x to 0 and y to the bottom clamp
        do_reset();
        for (int i = 0; i < 241; i++) send_pkt(8'h38, 8'h00, 8'hFF);
        settle();
        check("p4_x_clamp0", mouse_if.x, 0);
        check("p4_y_clampmax", mouse_if.y, 479);
        // dy=+127 moves up; repeated until the top clamp holds y at 0
        for (int i = 0; i < 5; i++) send_pkt(8'h08, 8'h00, 8'h7F);
        settle();
        check("p4_y_clamp0", mouse_if.y, 0);

        // Bad parity on byte 1, stray byte 2, then a clean packet
        do_reset();
        send_byte(8'h09, 0);
        send_byte(8'h05, 1);
        send_byte(8'h03, 0);
        send_pkt(8'h0A, 8'h01, 8'h01);
        settle();
        check("p5_btn_r", mouse_if.button_right, 1);
        check("p5_x", mouse_if.x, 321);
        check("p5_y", mouse_if.y, 239);

        // Header without sync bit, then a middle-button packet
        do_reset();
        send_byte(8'h01, 0);
        send_pkt(8'h0C, 8'h02, 8'h00);
        settle();
        check("p6_btn_m", mouse_if.button_middle, 1);
        check("p6_x", mouse_if.x, 322);

        // X overflow suppresses dx
        do_reset();
        send_pkt(8'h48, 8'h10, 8'h04);
        settle();
        check("p7_dx", mouse_if.dx, 0);
        check("p7_x", mouse_if.x, 320);
        check("p7_y", mouse_if.y, 236);

        // Reset mid-frame, then partial data must be gone
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        do_reset();
        send_pkt(8'h09, 8'h05, 8'h03);
        settle();
        check("p8_x", mouse_if.x, 325);
        check("p8_y", mouse_if.y, 237);

        repeat (3) @(negedge PS2_CLK);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
